pong_engine: RTL and testbench

Game-state core for the 64x64 Pong display. It advances ball motion, paddle motion, collisions, scoring and serve/game-over sequencing at a divided game-tick rate. It drives the ball, paddle and score inputs of the LED matrix renderer directly downstream. All outputs are registered and always legal for the renderer: coordinates stay in 0..63, paddles in 5..58, and scores in 0..WIN_SCORE.

---
 rtl/pong_engine.sv | 166 ++++++++++++++++
 tb/tb_pong_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_engine.sv
// pong_engine: Pong game-state core (ball, paddles, scoring, serve and game-over sequencing)
module pong_engine #(
    parameter int TICK_DIV    = 833333,
    parameter int SERVE_TICKS = 30,
    parameter int WIN_SCORE   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    output logic [5:0] bx,
    output logic [5:0] by,
    output logic [5:0] p1y,
    output logic [5:0] p2y,
    output logic [3:0] sc1,
    output logic [3:0] sc2,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SERVE_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        POINT    = 3'd3,
        GAMEOVER = 3'd4
    } state_t;

    state_t cur, nxt;
    logic [TW-1:0] tcnt;
    logic [SW-1:0] scnt, scnt_n;
    logic tick, dx, dy, dx_n, dy_n, scorer, scorer_n, game_over_n, winner_n;
    logic at_edge, hit, hdx, vdy;
    logic [5:0] bx_n, by_n, p1y_n, p2y_n, p1_mv, p2_mv, bx_mv, by_mv;
    logic [3:0] sc1_n, sc2_n, sc_new;

    // Paddle step with clamping to the legal 5..58 range; opposing buttons cancel.
    function automatic logic [5:0] paddle(input logic [5:0] p, input logic up, input logic dn);
        return (up && !dn && p > 6'd5) ? p - 6'd1 : (dn && !up && p < 6'd58) ? p + 6'd1 : p;
    endfunction

    // dx/dy and scorer use 1 for +1 / player 2 and 0 for -1 / player 1.
    assign tick    = tcnt == TW'(TICK_DIV - 1);
    assign state   = cur;
    assign p1_mv   = paddle(p1y, p1_up, p1_dn);
    assign p2_mv   = paddle(p2y, p2_up, p2_dn);
    assign at_edge = dx ? bx == 6'd61 : bx == 6'd2;
    assign hit     = dx ? (by >= p2y && by <= p2y + 6'd5) : (by >= p1y && by <= p1y + 6'd5);
    assign hdx     = at_edge ? ~dx : dx;
    assign vdy     = dy ? by != 6'd63 : by == 6'd0;
    assign bx_mv   = hdx ? bx + 6'd1 : bx - 6'd1;
    assign by_mv   = vdy ? by + 6'd1 : by - 6'd1;
    assign sc_new  = (scorer ? sc2 : sc1) + 4'd1;

    // Next-state and next-value logic for the game sequencer and datapath.
    always_comb begin
        nxt         = cur;
        bx_n        = bx;
        by_n        = by;
        dx_n        = dx;
        dy_n        = dy;
        p1y_n       = p1y;
        p2y_n       = p2y;
        sc1_n       = sc1;
        sc2_n       = sc2;
        scnt_n      = scnt;
        scorer_n    = scorer;
        game_over_n = game_over;
        winner_n    = winner;
        case (cur)
            IDLE, GAMEOVER: begin
                if (start) begin
                    nxt         = SERVE;
                    sc1_n       = '0;
                    sc2_n       = '0;
                    game_over_n = 1'b0;
                    bx_n        = 6'd31;
                    by_n        = 6'd32;
                    dx_n        = 1'b1;
                    dy_n        = 1'b1;
                    scnt_n      = '0;
                end
            end
            SERVE: begin
                if (tick) begin
                    p1y_n  = p1_mv;
                    p2y_n  = p2_mv;
                    scnt_n = scnt + SW'(1);
                    nxt    = scnt == SW'(SERVE_TICKS - 1) ? PLAY : SERVE;
                end
            end
            PLAY: begin
                if (tick) begin
                    p1y_n = p1_mv;
                    p2y_n = p2_mv;
                    if (at_edge && !hit) begin
                        nxt      = POINT;
                        scorer_n = ~dx;
                    end else begin
                        bx_n = bx_mv;
                        by_n = by_mv;
                        dx_n = hdx;
                        dy_n = vdy;
                    end
                end
            end
            POINT: begin
                sc1_n = scorer ? sc1 : sc_new;
                sc2_n = scorer ? sc_new : sc2;
                if (sc_new == 4'(WIN_SCORE)) begin
                    nxt         = GAMEOVER;
                    game_over_n = 1'b1;
                    winner_n    = scorer;
                end else begin
                    nxt    = SERVE;
                    bx_n   = 6'd31;
                    by_n   = 6'd32;
                    dx_n   = ~scorer;
                    scnt_n = '0;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // State, tick divider and every registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= IDLE;
            tcnt      <= '0;
            scnt      <= '0;
            bx        <= 6'd31;
            by        <= 6'd32;
            dx        <= 1'b1;
            dy        <= 1'b1;
            p1y       <= 6'd29;
            p2y       <= 6'd29;
            sc1       <= '0;
            sc2       <= '0;
            scorer    <= 1'b0;
            game_over <= 1'b0;
            winner    <= 1'b0;
        end else begin
            cur       <= nxt;
            tcnt      <= tick ? '0 : tcnt + TW'(1);
            scnt      <= scnt_n;
            bx        <= bx_n;
            by        <= by_n;
            dx        <= dx_n;
            dy        <= dy_n;
            p1y       <= p1y_n;
            p2y       <= p2y_n;
            sc1       <= sc1_n;
            sc2       <= sc2_n;
            scorer    <= scorer_n;
            game_over <= game_over_n;
            winner    <= winner_n;
        end
    end
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: table vectors, directed corner sequences and random play against a game model
module tb_pong_engine;
    localparam int TD = 4;
    localparam int ST = 2;
    localparam int WS = 7;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
    logic [5:0] bx, by, p1y, p2y;
    logic [3:0] sc1, sc2;
    logic game_over, winner;
    logic [2:0] state;

    int vectors = 0, miscompares = 0;
    int m_state, m_bx, m_by, m_dx, m_dy, m_p1, m_p2, m_s1, m_s2, m_go, m_win, m_tick, m_serve, m_scorer;

    typedef struct {
        logic st, u1, d1, u2, d2;
        int n, e_state, e_p1, e_p2, e_s1, e_s2, e_bx, e_by, e_go, e_win;
    } vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    pong_engine #(.TICK_DIV(TD), .SERVE_TICKS(ST), .WIN_SCORE(WS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
        .bx(bx), .by(by), .p1y(p1y), .p2y(p2y), .sc1(sc1), .sc2(sc2),
        .game_over(game_over), .winner(winner), .state(state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pad(input int p, input logic up, input logic dn);
        int q;
        q = p + int'(dn) - int'(up);
        return q < 5 ? 5 : (q > 58 ? 58 : q);
    endfunction

    task automatic model_reset();
        m_state = 0; m_bx = 31; m_by = 32; m_dx = 1; m_dy = 1;
        m_p1 = 29; m_p2 = 29; m_s1 = 0; m_s2 = 0; m_go = 0; m_win = 0;
        m_tick = 0; m_serve = 0; m_scorer = 0;
    endtask

    // One clock of the game as described by its rules: the ball reflects when it
    // would leave the field, and a paddle either reflects it or the point is lost.
    task automatic model_step();
        bit tk;
        int o1, o2, nx, ny, top;
        tk = (m_tick == TD - 1);
        m_tick = tk ? 0 : m_tick + 1;
        if ((m_state == 0 || m_state == 4) && start) begin
            m_s1 = 0; m_s2 = 0; m_go = 0; m_bx = 31; m_by = 32;
            m_dx = 1; m_dy = 1; m_state = 1; m_serve = 0;
        end else if (m_state == 3) begin
            if (m_scorer == 1) m_s1++; else m_s2++;
            if (m_s1 == WS || m_s2 == WS) begin
                m_state = 4; m_go = 1; m_win = (m_scorer == 2) ? 1 : 0;
            end else begin
                m_bx = 31; m_by = 32; m_dx = (m_scorer == 2) ? -1 : 1;
                m_state = 1; m_serve = 0;
            end
        end else if (tk && (m_state == 1 || m_state == 2)) begin
            o1 = m_p1; o2 = m_p2;
            m_p1 = pad(m_p1, p1_up, p1_dn);
            m_p2 = pad(m_p2, p2_up, p2_dn);
            if (m_state == 1) begin
                m_serve++;
                if (m_serve == ST) m_state = 2;
            end else begin
                nx = m_bx + m_dx;
                if (nx == 1 || nx == 62) begin
                    top = (nx == 1) ? o1 : o2;
                    if (m_by >= top && m_by <= top + 5) begin
                        m_dx = -m_dx;
                        nx = m_bx + m_dx;
                    end else begin
                        m_scorer = (nx == 1) ? 2 : 1;
                        m_state = 3;
                    end
                end
                if (m_state == 2) begin
                    ny = m_by + m_dy;
                    if (ny < 0 || ny > 63) begin
                        m_dy = -m_dy;
                        ny = m_by + m_dy;
                    end
                    m_bx = nx; m_by = ny;
                end
            end
        end
    endtask

    task automatic compare_model();
        check("bx", bx, m_bx);
        check("by", by, m_by);
        check("p1y", p1y, m_p1);
        check("p2y", p2y, m_p2);
        check("sc1", sc1, m_s1);
        check("sc2", sc2, m_s2);
        check("game_over", game_over, m_go);
        check("state", state, m_state);
        if (m_go == 1) check("winner", winner, m_win);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        check("rst bx", bx, 31);
        check("rst by", by, 32);
        check("rst p1y", p1y, 29);
        check("rst p2y", p2y, 29);
        check("rst sc1", sc1, 0);
        check("rst sc2", sc2, 0);
        check("rst game_over", game_over, 0);
        check("rst winner", winner, 0);
        check("rst state", state, 0);
        model_reset();
        {start, p1_up, p1_dn, p2_up, p2_dn} = '0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic steer(input int t1, input int t2, input int n);
        repeat (n) begin
            p1_up = m_p1 > t1; p1_dn = m_p1 < t1;
            p2_up = m_p2 > t2; p2_dn = m_p2 < t2;
            cycle();
        end
    endtask

    task automatic run_to_bx(input int t1, input int t2, input int target);
        bit found;
        found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            steer(t1, t2, 1);
            found = (m_state == 2 && m_bx == target);
        end
        if (!found) begin
            miscompares++;
            vectors++;
            $display("FAIL run_to_bx timeout: ball never reached column %0d (t=%0t)", target, $time);
        end
    endtask

    task automatic start_game();
        {p1_up, p1_dn, p2_up, p2_dn} = '0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("start state", state, 1);
    endtask

    // Rally that exercises both paddle edges and a wall bounce; lp1=8 hits at
    // by=p1y+5, lp1=7 misses at by=p1y+6.
    task automatic edge_game(input int lp1);
        do_reset();
        start_game();
        run_to_bx(5, 57, 61);
        check("p2 edge by", by, 62);
        check("p2 edge p2y", p2y, 57);
        steer(5, 57, TD);
        check("p2 edge hit bx", bx, 60);
        check("p2 edge hit by", by, 63);
        steer(5, 57, TD);
        check("bounce bx", bx, 59);
        check("bounce by", by, 62);
        run_to_bx(5, 49, 2);
        check("p1 top edge by", by, 5);
        check("p1 top edge p1y", p1y, 5);
        steer(5, 49, TD);
        check("p1 top edge hit bx", bx, 3);
        check("p1 top edge sc2", sc2, 0);
        run_to_bx(lp1, 49, 61);
        check("p2 low edge by", by, 54);
        check("p2 low edge p2y", p2y, 49);
        steer(lp1, 49, TD);
        check("p2 low edge hit bx", bx, 60);
        run_to_bx(lp1, 49, 53);
        check("wall pre by", by, 62);
        steer(lp1, 49, TD);
        check("wall 1 bx", bx, 52);
        check("wall 1 by", by, 63);
        steer(lp1, 49, TD);
        check("wall 2 bx", bx, 51);
        check("wall 2 by", by, 62);
        run_to_bx(lp1, 49, 2);
        check("p1 bottom by", by, 13);
        check("p1 bottom p1y", p1y, lp1);
        steer(lp1, 49, TD);
        if (lp1 == 8) begin
            check("p1y+5 hit bx", bx, 3);
            check("p1y+5 hit sc2", sc2, 0);
            check("p1y+5 hit state", state, 2);
        end else begin
            check("p1y+6 miss state", state, 3);
            check("p1y+6 miss bx", bx, 2);
            check("p1y+6 miss sc2", sc2, 0);
            steer(lp1, 49, 1);
            check("p1 miss sc2", sc2, 1);
            check("p1 miss state", state, 1);
            check("p1 miss centre bx", bx, 31);
            steer(lp1, 49, 10);
            check("serve hold bx", bx, 31);
            steer(lp1, 49, 1);
            check("serve toward p1 bx", bx, 30);
            check("serve toward p1 by", by, 31);
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,   8, 0, 29, 29, 0, 0, 31, 32, 0, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1,   1, 1, 29, 29, 0, 0, 31, 32, 0, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,   7, 2, 27, 31, 0, 0, 31, 32, 0, 0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 160, 2,  5, 58, 0, 0, 51, 54, 0, 0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,   8, 2,  5, 58, 0, 0, 49, 52, 0, 0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 193, 1, 53, 58, 0, 1, 31, 32, 0, 0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 768, 4, 58, 58, 0, 7,  2,  3, 1, 1};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,  20, 4, 58, 58, 0, 7,  2,  3, 1, 1};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0,   1, 1, 58, 58, 0, 0, 31, 32, 0, 0};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,   6, 2, 56, 56, 0, 0, 31, 32, 0, 0};
        do_reset();
        for (int r = 0; r < 10; r++) begin
            {start, p1_up, p1_dn, p2_up, p2_dn} = {tbl[r].st, tbl[r].u1, tbl[r].d1, tbl[r].u2, tbl[r].d2};
            repeat (tbl[r].n) cycle();
            check($sformatf("row%0d state", r), state, tbl[r].e_state);
            check($sformatf("row%0d p1y", r), p1y, tbl[r].e_p1);
            check($sformatf("row%0d p2y", r), p2y, tbl[r].e_p2);
            check($sformatf("row%0d sc1", r), sc1, tbl[r].e_s1);
            check($sformatf("row%0d sc2", r), sc2, tbl[r].e_s2);
            check($sformatf("row%0d bx", r), bx, tbl[r].e_bx);
            check($sformatf("row%0d by", r), by, tbl[r].e_by);
            check($sformatf("row%0d game_over", r), game_over, tbl[r].e_go);
            if (tbl[r].e_go == 1) check($sformatf("row%0d winner", r), winner, tbl[r].e_win);
        end
        start = 1'b0;
        repeat (10) cycle();
        do_reset();
        edge_game(7);
        edge_game(8);
        do_reset();
        start_game();
        run_to_bx(29, 56, 61);
        check("p2y+6 by", by, 62);
        check("p2y+6 p2y", p2y, 56);
        steer(29, 56, TD);
        check("p2 miss state", state, 3);
        check("p2 miss bx", bx, 61);
        check("p2 miss sc1", sc1, 0);
        steer(29, 56, 1);
        check("p2 miss sc1 next", sc1, 1);
        check("p2 miss serve state", state, 1);
        steer(29, 56, 10);
        check("serve hold bx p2", bx, 31);
        steer(29, 56, 1);
        check("serve toward p2 bx", bx, 32);
        check("serve toward p2 by", by, 33);
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 7) == 0) {p1_up, p1_dn, p2_up, p2_dn} = 4'($urandom);
            start = ($urandom_range(0, 99) == 0);
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
